// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational unsigned multiplier between NREQ requesters.
// Operands are registered into the multiplier and the product is returned, tagged with the
// requester index, over a valid/ready response channel. One operation is in flight at a time.
// Optional build macro MUL_ARB_STATS_EN adds the op_count and last_grant outputs.
module mul_share_arbiter #(
  parameter int unsigned SIZE = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*SIZE-1:0]   req_a,
  input  logic [NREQ*SIZE-1:0]   req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [2*SIZE-1:0]      resp_y,
  input  logic                   resp_ready,
  output logic                   busy
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [15:0]            op_count,
  output logic [ID_W-1:0]        last_grant
`endif
);

  localparam logic [ID_W-1:0] LastId = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [SIZE-1:0]     op_a_q, op_a_d;
  logic [SIZE-1:0]     op_b_q, op_b_d;
  logic [2*SIZE-1:0]   resp_y_q, resp_y_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic                resp_valid_q, resp_valid_d;

  logic [2*NREQ-1:0]   valid_dbl;
  logic [NREQ-1:0]     valid_rot;
  logic [ID_W-1:0]     grant;
  logic                grant_found;
  logic [SIZE-1:0]     sel_a, sel_b;

  // Shared multiplier: its inputs are driven only from the operand registers.
  logic [SIZE-1:0]     mul_a, mul_b;
  logic [2*SIZE-1:0]   mul_y;

  assign mul_a = op_a_q;
  assign mul_b = op_b_q;
  assign mul_y = {{SIZE{1'b0}}, mul_a} * {{SIZE{1'b0}}, mul_b};

  // Rotate the valid vector so bit 0 is the rr_ptr requester, then take the first set bit.
  always_comb begin
    int tmp;
    tmp         = 0;
    grant       = '0;
    grant_found = 1'b0;
    valid_dbl   = {req_valid, req_valid} >> rr_ptr_q;
    valid_rot   = valid_dbl[NREQ-1:0];
    for (int k = 0; k < NREQ; k++) begin
      if (valid_rot[k] && !grant_found) begin
        tmp = int'(rr_ptr_q) + k;
        if (tmp >= int'(NREQ)) begin
          tmp = tmp - int'(NREQ);
        end
        grant       = tmp[ID_W-1:0];
        grant_found = 1'b1;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == i[ID_W-1:0]) begin
        sel_a = req_a[i*SIZE +: SIZE];
        sel_b = req_b[i*SIZE +: SIZE];
      end
    end
  end

  // Accept is combinational and only ever offered in IDLE outside reset.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_found && !rst) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Next-state logic for the IDLE -> CALC -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_y_d     = resp_y_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          id_d    = grant;
          state_d = StCalc;
        end
      end
      StCalc: begin
        resp_y_d     = mul_y;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        // The pointer moves only once the response has actually been taken.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = (id_q == LastId) ? '0 : id_q + 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_y_q     <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_y_q     <= resp_y_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_y     = resp_y_q;
  assign busy       = (state_q != StIdle);

`ifdef MUL_ARB_STATS_EN
  logic [15:0]     op_count_q;
  logic [ID_W-1:0] last_grant_q;

  // Completed-handshake counter (wraps) and index of the most recent accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q   <= '0;
      last_grant_q <= '0;
    end else begin
      if (state_q == StResp && resp_ready) begin
        op_count_q <= op_count_q + 16'd1;
      end
      if (state_q == StIdle && grant_found) begin
        last_grant_q <= grant;
      end
    end
  end

  assign op_count   = op_count_q;
  assign last_grant = last_grant_q;
`else
  // Default build carries no statistics state.
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one combinational MUL #(SIZE) instance, with ports A, B and Y, between NREQ independent requesters.
- Requests use a valid/ready handshake and are arbitrated round-robin.
- Operands are registered into the multiplier, and the product is registered and returned with the requester's ID over a valid/ready response channel.
- Sits between the CA3 datapath units and the shared multiplier; it is the only driver of the MUL inputs.

Parameters:
SIZE, 8, operand width; product is 2*SIZE bits.
NREQ, 4, number of requesters (2..8).
ID_W, 2, requester ID width; must satisfy 2**ID_W >= NREQ.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  NREQ  per-requester request valid.
req_a  input  NREQ*SIZE  packed operand A; requester i uses bits [i*SIZE +: SIZE].
req_b  input  NREQ*SIZE  packed operand B, same packing as req_a.
req_ready  output  NREQ  one-hot accept; at most one bit high per cycle.
resp_valid  output  1  result valid.
resp_id  output  ID_W  index of the requester owning resp_y.
resp_y  output  2*SIZE  unsigned product.
resp_ready  input  1  consumer accepts the result.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_y=0, busy=0, operand registers=0.
- req_ready is combinational and is 0 on any cycle where rst=1.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[grant]=1 in the same cycle; all other req_ready bits are 0.
  - At the clock edge: latch req_a/req_b slice of grant into op_a/op_b, latch grant into id_r, go to CALC.
  - No req_valid set: stay in IDLE, all req_ready=0.
- CALC:
  - MUL.A=op_a, MUL.B=op_b.
  - At the edge: resp_y<=MUL.Y, resp_id<=id_r, resp_valid<=1, go to RESP.
- RESP:
  - resp_valid=1; resp_y and resp_id held stable until resp_valid && resp_ready.
  - On handshake: resp_valid<=0, rr_ptr<=(id_r+1) mod NREQ, go to IDLE.
  - resp_ready=0: stay in RESP indefinitely with outputs held.
- req_ready is 0 in CALC and RESP; requesters keep req_valid and operands stable until accepted.
- Latency: accept edge t → resp_valid high from t+2. Minimum initiation interval 3 cycles.
- Arithmetic: unsigned, full 2*SIZE-bit product, no truncation (255*255=65025 for SIZE=8).
- Simultaneous requests: only one is granted per IDLE cycle; the rest wait.
- Fairness: a continuously valid requester is served within NREQ grants.
- Deasserting req_valid before acceptance withdraws the request; no state changes.
- rr_ptr advances only on a completed response, never on reset or idle cycles.
- Reset mid-operation (CALC or RESP): the in-flight result is discarded, no response is issued, and all registers take their reset values next cycle.
- resp_ready while resp_valid=0 is ignored.

Optional Feature:
MUL_ARB_STATS_EN:
- Defined: adds output op_count [15:0], reset to 0, incremented by 1 on each resp_valid && resp_ready handshake, wrapping 65535 → 0.
- Adds output last_grant [ID_W-1:0], reset to 0, updated on each accept.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Single request: req0 A=3, B=2 accepted at t, resp_ready=1 → resp_valid at t+2 with resp_y=6, resp_id=0; req_ready[0] high for exactly one cycle.
- Max and zero operands: req2 A=255, B=255 → resp_y=65025, resp_id=2; then req1 A=15, B=0 → resp_y=0, resp_id=1.
- Round-robin: all four requesters valid continuously after reset → grant order 0,1,2,3,0; each grant is followed by one response carrying the correct product (e.g. req3 A=22, B=5 → 110).
- Backpressure: req0 A=1, B=170, resp_ready held low 5 cycles → resp_valid stays 1 with resp_y=170, resp_id=0 stable; req_ready all 0 and busy=1 throughout; completes on first resp_ready=1.
- Reset mid-op: assert rst in CALC → no response, next cycle state IDLE, resp_valid=0, rr_ptr=0; a fresh req1 A=3, B=3 then returns 9.
- With MUL_ARB_STATS_EN: after 3 completed ops → op_count=3; after rst → op_count=0.
